// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared definitions for the single-port SRAM controller:
//               default geometry constants and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int c_data_width = 2;
    localparam int c_addr_width = 4;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } ctrl_state_t;

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_16x2.sv
`default_nettype none
// ============================================================================
// Module      : sram_16x2
// Description : Behavioural model of a 16-word x 2-bit single-port SRAM macro
//               with active-low controls. Reads and writes are sampled on
//               posedge clk0; read data appears on dout0 after that edge and
//               holds until the next read.
// Ports       : clk0  - clock
//               csb0  - active-low chip select
//               web0  - active-low write enable
//               addr0 - word address
//               din0  - write data
//               dout0 - read data
// Revision    : 1.0 - initial release
// ============================================================================
module sram_16x2 (
    input  logic       clk0,
    input  logic       csb0,
    input  logic       web0,
    input  logic [3:0] addr0,
    input  logic [1:0] din0,
    output logic [1:0] dout0
);

    logic [1:0] r_mem [0:15];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                r_mem[addr0] <= din0;
            end else begin
                dout0 <= r_mem[addr0];
            end
        end
    end

endmodule : sram_16x2
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_ctrl
// Description : Valid/ready request/response front-end for a single-port
//               SRAM. After reset it clears every word to zero, then accepts
//               one write per cycle or one outstanding read at a time. All
//               SRAM pins are registered.
// Ports       : clk0       - clock
//               rst0       - synchronous active-high reset
//               req_valid  - request offered
//               req_ready  - request accepted (IDLE and init complete)
//               req_we     - 1 = write, 0 = read
//               req_addr   - request address
//               req_wdata  - write data
//               rsp_valid  - read data valid
//               rsp_ready  - response consumed
//               rsp_rdata  - read data
//               init_done  - memory clear complete
//               csb0/web0/addr0/din0 - SRAM control, address, write data
//               dout0      - SRAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

    ctrl_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            csb0       <= 1'b1;
            web0       <= 1'b1;
            addr0      <= '0;
            din0       <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            init_done  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    csb0       <= 1'b0;
                    web0       <= 1'b0;
                    addr0      <= r_init_cnt;
                    din0       <= '0;
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == c_last_addr) begin
                        // Last clear write is on the pins during the first
                        // IDLE cycle; a request accepted then lands after it.
                        r_state   <= IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end

                IDLE: begin
                    if (req_valid && req_ready) begin
                        csb0  <= 1'b0;
                        addr0 <= req_addr;
                        if (req_we) begin
                            web0 <= 1'b0;
                            din0 <= req_wdata;
                        end else begin
                            web0      <= 1'b1;
                            req_ready <= 1'b0;
                            r_state   <= RD_ISSUE;
                        end
                    end else begin
                        csb0 <= 1'b1;
                        web0 <= 1'b1;
                    end
                end

                RD_ISSUE: begin
                    // The macro samples the read on this edge; data is on
                    // dout0 before the next one.
                    csb0    <= 1'b1;
                    web0    <= 1'b1;
                    r_state <= RD_WAIT;
                end

                RD_WAIT: begin
                    rsp_rdata <= dout0;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule : sram_port_ctrl
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_ctrl
// Description : Directed self-checking bench for sram_port_ctrl connected to
//               a sram_16x2 macro model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_ctrl;

    logic       clk0 = 1'b0;
    logic       rst0;
    logic       req_valid;
    logic       req_we;
    logic [3:0] req_addr;
    logic [1:0] req_wdata;
    logic       rsp_ready;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_rdata;
    logic       init_done;
    logic       csb0;
    logic       web0;
    logic [3:0] addr0;
    logic [1:0] din0;
    logic [1:0] dout0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk0 = ~clk0;

    sram_port_ctrl #(
        .DATA_WIDTH (2),
        .ADDR_WIDTH (4)
    ) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    sram_16x2 u_sram (
        .clk0  (clk0),
        .csb0  (csb0),
        .web0  (web0),
        .addr0 (addr0),
        .din0  (din0),
        .dout0 (dout0)
    );

    // Present one request for exactly one edge; called and returns on a negedge.
    task automatic issue_req(input logic we, input logic [3:0] a, input logic [1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk0);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 4'd0; req_wdata = 2'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk0);
        n_checks++; if (csb0 !== 1'b1) begin n_fail++; $display("FAIL reset_csb0: got %b expected 1", csb0); end
        n_checks++; if (web0 !== 1'b1) begin n_fail++; $display("FAIL reset_web0: got %b expected 1", web0); end
        n_checks++; if (addr0 !== 4'd0) begin n_fail++; $display("FAIL reset_addr0: got %h expected 0", addr0); end
        n_checks++; if (din0 !== 2'd0) begin n_fail++; $display("FAIL reset_din0: got %h expected 0", din0); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    endtask

    task automatic test_init();
        // Offer a read throughout INIT; it must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        rst0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk0);
            n_checks++; if (addr0 !== 4'(i)) begin n_fail++; $display("FAIL init_addr0[%0d]: got %0d expected %0d", i, addr0, i); end
            n_checks++; if ({csb0, web0, din0} !== 4'b0000) begin n_fail++; $display("FAIL init_pins[%0d]: got csb0=%b web0=%b din0=%h expected 0,0,0", i, csb0, web0, din0); end
            n_checks++; if (req_ready !== (i == 15)) begin n_fail++; $display("FAIL init_req_ready[%0d]: got %b expected %b", i, req_ready, (i == 15)); end
            n_checks++; if (init_done !== (i == 15)) begin n_fail++; $display("FAIL init_done[%0d]: got %b expected %b", i, init_done, (i == 15)); end
            if (i == 15) req_valid = 1'b0;
        end
        @(negedge clk0);
        n_checks++; if ({csb0, web0} !== 2'b11) begin n_fail++; $display("FAIL idle_pins: got csb0=%b web0=%b expected 1,1", csb0, web0); end
        n_checks++; if ({init_done, req_ready} !== 2'b11) begin n_fail++; $display("FAIL idle_flags: got init_done=%b req_ready=%b expected 1,1", init_done, req_ready); end
    endtask

    task automatic test_read_cleared();
        rsp_ready = 1'b1;
        issue_req(1'b0, 4'd9, 2'd0);
        n_checks++; if ({csb0, web0, addr0} !== {1'b0, 1'b1, 4'd9}) begin n_fail++; $display("FAIL rd9_issue: got csb0=%b web0=%b addr0=%0d expected 0,1,9", csb0, web0, addr0); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rd9_req_ready: got %b expected 0", req_ready); end
        @(negedge clk0);
        n_checks++; if ({csb0, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rd9_wait: got csb0=%b rsp_valid=%b expected 1,0", csb0, rsp_valid); end
        @(negedge clk0);
        n_checks++; if ({rsp_valid, rsp_rdata} !== 3'b100) begin n_fail++; $display("FAIL rd9_resp: got valid=%b rdata=%h expected 1,0", rsp_valid, rsp_rdata); end
        @(negedge clk0);
        n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL rd9_done: got rsp_valid=%b req_ready=%b expected 0,1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        issue_req(1'b1, 4'd4, 2'b10);
        n_checks++; if ({csb0, web0, addr0, din0} !== {1'b0, 1'b0, 4'd4, 2'b10}) begin n_fail++; $display("FAIL wr4_pins: got csb0=%b web0=%b addr0=%0d din0=%h expected 0,0,4,2", csb0, web0, addr0, din0); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr4_req_ready: got %b expected 1", req_ready); end
        issue_req(1'b0, 4'd4, 2'd0);
        n_checks++; if ({csb0, web0, addr0} !== {1'b0, 1'b1, 4'd4}) begin n_fail++; $display("FAIL rd4_issue: got csb0=%b web0=%b addr0=%0d expected 0,1,4", csb0, web0, addr0); end
        @(negedge clk0);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd4_early_valid: got %b expected 0", rsp_valid); end
        @(negedge clk0);
        n_checks++; if ({rsp_valid, rsp_rdata} !== 3'b110) begin n_fail++; $display("FAIL rd4_resp: got valid=%b rdata=%h expected 1,2", rsp_valid, rsp_rdata); end
        @(negedge clk0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_d [0:3];
        exp_d[0] = 2'd1; exp_d[1] = 2'd2; exp_d[2] = 2'd3; exp_d[3] = 2'd0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = exp_d[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk0);
            n_checks++; if ({csb0, web0, addr0, din0} !== {1'b0, 1'b0, 4'(i), exp_d[i]}) begin n_fail++; $display("FAIL b2b_wr[%0d]: got csb0=%b web0=%b addr0=%0d din0=%h expected 0,0,%0d,%h", i, csb0, web0, addr0, din0, i, exp_d[i]); end
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
            if (i < 3) begin
                req_addr  = 4'(i + 1);
                req_wdata = exp_d[i + 1];
            end else begin
                req_valid = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            issue_req(1'b0, 4'(i), 2'd0);
            repeat (2) @(negedge clk0);
            n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, exp_d[i]}) begin n_fail++; $display("FAIL b2b_rd[%0d]: got valid=%b rdata=%h expected 1,%h", i, rsp_valid, rsp_rdata, exp_d[i]); end
            @(negedge clk0);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue_req(1'b1, 4'd7, 2'd3);
        issue_req(1'b0, 4'd7, 2'd0);
        repeat (2) @(negedge clk0);
        n_checks++; if ({rsp_valid, rsp_rdata} !== 3'b111) begin n_fail++; $display("FAIL bp_resp: got valid=%b rdata=%h expected 1,3", rsp_valid, rsp_rdata); end
        // A write offered while stalled must not reach the SRAM.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk0);
            n_checks++; if ({rsp_valid, rsp_rdata} !== 3'b111) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h expected 1,3", i, rsp_valid, rsp_rdata); end
            n_checks++; if ({req_ready, csb0} !== 2'b01) begin n_fail++; $display("FAIL bp_block[%0d]: got req_ready=%b csb0=%b expected 0,1", i, req_ready, csb0); end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk0);
        n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got rsp_valid=%b req_ready=%b expected 0,1", rsp_valid, req_ready); end
        issue_req(1'b0, 4'd0, 2'd0);
        repeat (2) @(negedge clk0);
        n_checks++; if ({rsp_valid, rsp_rdata} !== 3'b101) begin n_fail++; $display("FAIL bp_ignored_wr: got valid=%b rdata=%h expected 1,1", rsp_valid, rsp_rdata); end
        @(negedge clk0);
    endtask

    task automatic test_reset_mid_read();
        int waited;
        rsp_ready = 1'b1;
        issue_req(1'b0, 4'd1, 2'd0);
        @(negedge clk0);
        rst0 = 1'b1;
        @(negedge clk0);
        n_checks++; if ({csb0, rsp_valid, init_done, req_ready} !== 4'b1000) begin n_fail++; $display("FAIL rst_abort: got csb0=%b rsp_valid=%b init_done=%b req_ready=%b expected 1,0,0,0", csb0, rsp_valid, init_done, req_ready); end
        n_checks++; if (addr0 !== 4'd0) begin n_fail++; $display("FAIL rst_addr0: got %0d expected 0", addr0); end
        rst0 = 1'b0;
        @(negedge clk0);
        n_checks++; if ({csb0, web0, addr0, rsp_valid} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL reinit_first: got csb0=%b web0=%b addr0=%0d rsp_valid=%b expected 0,0,0,0", csb0, web0, addr0, rsp_valid); end
        @(negedge clk0);
        n_checks++; if (addr0 !== 4'd1) begin n_fail++; $display("FAIL reinit_second: got %0d expected 1", addr0); end
        waited = 0;
        while (!init_done && waited < 20) begin
            @(negedge clk0);
            waited++;
        end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL reinit_timeout: got init_done=%b expected 1", init_done); end
        if (init_done === 1'b1) begin
            issue_req(1'b0, 4'd4, 2'd0);
            repeat (2) @(negedge clk0);
            n_checks++; if ({rsp_valid, rsp_rdata} !== 3'b100) begin n_fail++; $display("FAIL reinit_cleared: got valid=%b rdata=%h expected 1,0", rsp_valid, rsp_rdata); end
            @(negedge clk0);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read_cleared();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sram_port_ctrl
`default_nettype wire
